// File: rtl/arp_tx.sv
// ARP request/reply frame transmitter on a GMII byte stream.
// Emits preamble, Ethernet header, padded ARP payload and CRC-32 FCS, then an inter-frame gap.
module arp_tx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [47:0] DES_MAC   = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [31:0] DES_IP    = {8'd192, 8'd168, 8'd1, 8'd102}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_done,
  output logic [5:0]  fsm_state
);

  // Handshake: arp_tx_en is a one-cycle request sampled only in IDLE; there is no
  // back-pressure, so a pulse seen in any other state is simply dropped.

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    PREAMBLE = 6'b000010,
    ETH_HEAD = 6'b000100,
    ARP_DATA = 6'b001000,
    CRC      = 6'b010000,
    IFG      = 6'b100000
  } state_t;

  state_t      state, next_state;
  logic [6:0]  cnt, next_cnt;
  logic        typ_q;
  logic [47:0] mac_q;
  logic [31:0] ip_q;
  logic [31:0] crc_q, crc_next;

  logic        next_en;
  logic [7:0]  next_txd;
  logic [47:0] dst_mac;
  logic [47:0] tgt_mac;
  logic [111:0] eth_hdr, eth_sh;
  logic [223:0] arp_pl, arp_sh;
  logic [31:0]  fcs_sh;
  logic [9:0]   bit_ofs;

  assign fsm_state = state;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    next_state = state;
    next_cnt   = cnt + 7'd1;
    case (state)
      IDLE: begin
        next_cnt = 7'd0;
        if (arp_tx_en) next_state = PREAMBLE;
      end
      PREAMBLE: if (cnt == 7'd7)  next_state = ETH_HEAD;
      ETH_HEAD: if (cnt == 7'd13) next_state = ARP_DATA;
      ARP_DATA: if (cnt == 7'd45) next_state = CRC;
      CRC:      if (cnt == 7'd3)  next_state = IFG;
      IFG:      if (cnt == 7'd11) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (next_state != state) next_cnt = 7'd0;
  end

  // Outputs are registered, so the byte loaded at each edge is the one for (next_state, next_cnt).
  always_comb begin
    dst_mac  = typ_q ? mac_q : 48'hff_ff_ff_ff_ff_ff;
    tgt_mac  = typ_q ? mac_q : 48'h0;
    eth_hdr  = {dst_mac, BOARD_MAC, 16'h0806};
    arp_pl   = {16'h0001, 16'h0800, 8'h06, 8'h04, (typ_q ? 16'h0002 : 16'h0001),
                BOARD_MAC, BOARD_IP, tgt_mac, ip_q};
    bit_ofs  = {next_cnt, 3'b000};
    eth_sh   = eth_hdr << bit_ofs;
    arp_sh   = arp_pl << bit_ofs;   // indices past 27 shift everything out, giving the zero pad
    fcs_sh   = (~crc_q) >> bit_ofs;
    next_en  = 1'b0;
    next_txd = 8'h00;
    case (next_state)
      PREAMBLE: begin
        next_en  = 1'b1;
        next_txd = (next_cnt == 7'd7) ? 8'hD5 : 8'h55;
      end
      ETH_HEAD: begin
        next_en  = 1'b1;
        next_txd = eth_sh[111:104];
      end
      ARP_DATA: begin
        next_en  = 1'b1;
        next_txd = arp_sh[223:216];
      end
      CRC: begin
        next_en  = 1'b1;
        next_txd = fcs_sh[7:0];
      end
      default: begin
        next_en  = 1'b0;
        next_txd = 8'h00;
      end
    endcase
    crc_next = crc32_byte(crc_q, next_txd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 7'd0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
      tx_done    <= 1'b0;
      typ_q      <= 1'b0;
      mac_q      <= 48'h0;
      ip_q       <= 32'h0;
      crc_q      <= 32'hFFFFFFFF;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      gmii_tx_en <= next_en;
      gmii_txd   <= next_txd;
      tx_done    <= (state == CRC) && (next_state == IFG);
      if (state == IDLE && arp_tx_en) begin
        typ_q <= arp_tx_type;
        mac_q <= (des_mac == 48'h0) ? DES_MAC : des_mac;
        ip_q  <= (des_ip == 32'h0) ? DES_IP : des_ip;
        crc_q <= 32'hFFFFFFFF;
      end else if (next_state == ETH_HEAD || next_state == ARP_DATA) begin
        crc_q <= crc_next;
      end
    end
  end

endmodule

// File: tb/tb_arp_tx.sv
// Bench for arp_tx: a reference model queues every expected frame byte and a
// negedge monitor pops and compares whatever the DUT puts on GMII.
module tb_arp_tx;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = 32'hC0A8010A;
  localparam logic [47:0] DES_MAC   = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [31:0] DES_IP    = 32'hC0A80166;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arp_tx_en = 1'b0;
  logic        arp_tx_type = 1'b0;
  logic [47:0] des_mac = 48'h0;
  logic [31:0] des_ip = 32'h0;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        tx_done;
  logic [5:0]  fsm_state;

  arp_tx #(
    .BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP), .DES_MAC(DES_MAC), .DES_IP(DES_IP)
  ) dut (
    .clk(clk), .rst(rst), .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
    .des_mac(des_mac), .des_ip(des_ip), .gmii_tx_en(gmii_tx_en),
    .gmii_txd(gmii_txd), .tx_done(tx_done), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_q[$];
  logic [31:0] crc_tab[256];
  int n_checks = 0;
  int n_fail = 0;
  int exp_done = 0;
  int done_seen = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Table-driven reflected CRC-32 reference.
  task automatic build_crc_table();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] r;
      r = i;
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      crc_tab[i] = r;
    end
  endtask

  function automatic logic [31:0] tab_crc(input logic [31:0] c, input logic [7:0] d);
    logic [7:0] idx;
    idx = c[7:0] ^ d;
    return (c >> 8) ^ crc_tab[idx];
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Reference model: assemble the whole frame from the field rules and queue it.
  task automatic push_frame(input bit typ, input logic [47:0] mac, input logic [31:0] ip);
    logic [7:0]  b[$];
    logic [47:0] m, dst, tmac;
    logic [31:0] tip, crc, fcs;
    m    = (mac == 48'h0) ? DES_MAC : mac;
    tip  = (ip == 32'h0) ? DES_IP : ip;
    dst  = typ ? m : 48'hff_ff_ff_ff_ff_ff;
    tmac = typ ? m : 48'h0;
    for (int i = 0; i < 7; i++) b.push_back(8'h55);
    b.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) b.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(BOARD_MAC[8*i +: 8]);
    b.push_back(8'h08); b.push_back(8'h06);
    b.push_back(8'h00); b.push_back(8'h01); b.push_back(8'h08); b.push_back(8'h00);
    b.push_back(8'h06); b.push_back(8'h04); b.push_back(8'h00); b.push_back(typ ? 8'h02 : 8'h01);
    for (int i = 5; i >= 0; i--) b.push_back(BOARD_MAC[8*i +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(BOARD_IP[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(tmac[8*i +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(tip[8*i +: 8]);
    while (b.size() < 68) b.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    for (int i = 8; i < 68; i++) crc = tab_crc(crc, b[i]);
    fcs = ~crc;
    for (int i = 0; i < 4; i++) b.push_back(fcs[8*i +: 8]);
    foreach (b[i]) exp_q.push_back(b[i]);
    exp_done++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input bit typ, input logic [47:0] mac, input logic [31:0] ip);
    push_frame(typ, mac, ip);
    arp_tx_type = typ;
    des_mac     = mac;
    des_ip      = ip;
    arp_tx_en   = 1'b1;
    @(posedge clk);
    #1;
    arp_tx_en   = 1'b0;
    arp_tx_type = 1'($urandom_range(0, 1));
    des_mac     = {16'($urandom), 32'($urandom)};
    des_ip      = 32'($urandom);
    check(gmii_tx_en === 1'b1 && gmii_txd === 8'h55, "first_preamble", {gmii_tx_en, gmii_txd}, 9'h155);
  endtask

  task automatic pulse_ignored();
    arp_tx_type = 1'($urandom_range(0, 1));
    des_mac     = {16'($urandom), 32'($urandom)};
    des_ip      = 32'($urandom);
    arp_tx_en   = 1'b1;
    @(posedge clk);
    #1;
    arp_tx_en   = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk);
      #1;
      if (tx_done) got = 1'b1;
    end
    if (!got) check(1'b0, "done_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  int         run_len = 0;
  bit         prev_en = 1'b0;
  logic [7:0] fbuf[72];
  logic [7:0] mon_exp;
  logic [31:0] residue;

  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
      prev_en = 1'b0;
    end else begin
      if (gmii_tx_en) begin
        if (!prev_en) run_len = 0;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_byte", gmii_txd, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check(gmii_txd === mon_exp, "frame_byte", gmii_txd, mon_exp);
        end
        if (run_len < 72) fbuf[run_len] = gmii_txd;
        run_len++;
      end else begin
        check(gmii_txd === 8'h00, "idle_txd", gmii_txd, 0);
      end
      if (tx_done) begin
        done_seen++;
        check(prev_en && !gmii_tx_en, "done_timing", {prev_en, gmii_tx_en}, 2'b10);
        check(run_len == 72, "frame_len", run_len, 72);
        if (run_len == 72) begin
          residue = 32'hFFFFFFFF;
          for (int i = 8; i < 72; i++) residue = tab_crc(residue, fbuf[i]);
          check(bitrev32(residue) == 32'hC704DD7B, "fcs_residue", bitrev32(residue), 32'hC704DD7B);
        end
      end
      prev_en = gmii_tx_en;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    build_crc_table();
    rst = 1'b1;
    idle_cycles(3);
    check(gmii_tx_en === 1'b0, "rst_tx_en", gmii_tx_en, 0);
    check(gmii_txd === 8'h00, "rst_txd", gmii_txd, 0);
    check(tx_done === 1'b0, "rst_tx_done", tx_done, 0);
    check(fsm_state === 6'b000001, "rst_state", fsm_state, 6'b000001);
    rst = 1'b0;
    idle_cycles(3);

    // Request to the default peer.
    send_frame(1'b0, 48'h0, DES_IP);
    wait_done();
    idle_cycles(14);

    // Reply with explicit target MAC.
    send_frame(1'b1, 48'hA0B1C2D3E4F5, 32'h0A000001);
    wait_done();
    idle_cycles(14);

    // Fallback addresses.
    send_frame(1'b1, 48'h0, 32'h0);
    wait_done();
    idle_cycles(14);

    // Start pulses while busy and during the gap are dropped; one 13 cycles after tx_done is taken.
    send_frame(1'b0, 48'h0, DES_IP);
    idle_cycles(30);
    pulse_ignored();
    wait_done();
    idle_cycles(5);
    pulse_ignored();
    idle_cycles(7);
    send_frame(1'b1, 48'h665544332211, 32'hC0A80105);
    wait_done();
    idle_cycles(14);

    // Reset in the middle of a frame truncates it with no tx_done.
    send_frame(1'b0, 48'h0, DES_IP);
    idle_cycles(40);
    #2;
    rst = 1'b1;
    #1;
    check(gmii_tx_en === 1'b0, "midrst_tx_en", gmii_tx_en, 0);
    check(gmii_txd === 8'h00, "midrst_txd", gmii_txd, 0);
    check(tx_done === 1'b0, "midrst_tx_done", tx_done, 0);
    exp_q.delete();
    exp_done--;
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(20);
    send_frame(1'b0, 48'h0, DES_IP);
    wait_done();
    idle_cycles(14);

    // Randomized frames.
    for (int n = 0; n < 10; n++) begin
      bit          typ;
      logic [47:0] mac;
      logic [31:0] ip;
      typ = 1'($urandom_range(0, 1));
      mac = ($urandom_range(0, 3) == 0) ? 48'h0 : {16'($urandom), 32'($urandom)};
      ip  = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      send_frame(typ, mac, ip);
      wait_done();
      idle_cycles($urandom_range(12, 20));
    end

    idle_cycles(5);
    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
    check(done_seen == exp_done, "done_count", done_seen, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
